// File: rtl/nco_burst_ctrl_if.sv
// Burst-control bundle between the acquisition sequencer, the NCO core and the controller.
// The controller is the slave side; the sequencer/NCO/testbench drive the master side.
interface nco_burst_ctrl_if #(
  parameter int APR  = 32,
  parameter int CNTW = 16
);
  logic            start;
  logic            abort;
  logic [APR-1:0]  cfg_inc;
  logic [APR-1:0]  cfg_step;
  logic [CNTW-1:0] cfg_len;
  logic            nco_valid;
  logic            nco_clken;
  logic [APR-1:0]  nco_phi_inc;
  logic            smp_valid;
  logic [CNTW-1:0] smp_idx;
  logic            busy;
  logic            done;
  logic            err;

  modport slave (
    input  start, abort, cfg_inc, cfg_step, cfg_len, nco_valid,
    output nco_clken, nco_phi_inc, smp_valid, smp_idx, busy, done, err
  );

  modport master (
    output start, abort, cfg_inc, cfg_step, cfg_len, nco_valid,
    input  nco_clken, nco_phi_inc, smp_valid, smp_idx, busy, done, err
  );
endinterface

// File: rtl/nco_burst_ctrl.sv
// Sequences an NCO core through one acquisition burst: pipeline fill, then exactly
// cfg_len qualified samples with an optional linear chirp on the phase increment.
module nco_burst_ctrl #(
  parameter int APR  = 32,
  parameter int CNTW = 16,
  parameter int LAT  = 8,
  parameter int TMO  = 4
) (
  input logic            clk,
  input logic            reset_n,
  nco_burst_ctrl_if.slave bus
);
  localparam int FW = $clog2(LAT + TMO + 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t          state;
  logic            clken_q, busy_q, done_q, err_q;
  logic [APR-1:0]  phi_q, step_q;
  logic [CNTW-1:0] len_q, idx_q;
  logic [FW-1:0]   fill_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      clken_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      phi_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      fill_q  <= '0;
    end else if (bus.abort) begin
      // abort drops the burst silently: no done pulse, err left as-is
      state   <= IDLE;
      clken_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            step_q <= bus.cfg_step;
            len_q  <= bus.cfg_len;
            err_q  <= 1'b0;
            fill_q <= '0;
            if (bus.cfg_len != '0) begin
              state   <= PRIME;
              phi_q   <= bus.cfg_inc;
              clken_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        PRIME: begin
          if (bus.nco_valid) begin
            state <= RUN;
          end else if (fill_q == FW'(LAT + TMO - 1)) begin
            state   <= DONE;
            err_q   <= 1'b1;
            clken_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            fill_q <= fill_q + 1'b1;
          end
        end
        RUN: begin
          // chirp applies after each flagged sample; gaps in nco_valid hold everything
          if (bus.nco_valid) begin
            idx_q <= idx_q + 1'b1;
            phi_q <= phi_q + step_q;
            if (idx_q == len_q - CNTW'(1)) begin
              state   <= DONE;
              clken_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          idx_q  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.nco_clken   = clken_q;
  assign bus.nco_phi_inc = phi_q;
  assign bus.smp_valid   = (state == RUN) & bus.nco_valid;
  assign bus.smp_idx     = idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_nco_burst_ctrl.sv
// Directed bench for nco_burst_ctrl: expected samples/done events are queued at stimulus
// time and a negedge monitor pops and compares them as the DUT presents them.
module tb_nco_burst_ctrl;
  localparam int APR = 32, CNTW = 16, LAT = 8, TMO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;
  int   hi_cnt = 0, sv_cnt = 0;
  logic nco_en = 1'b1;
  int   fill = 0;

  nco_burst_ctrl_if #(.APR(APR), .CNTW(CNTW)) bus ();

  nco_burst_ctrl #(.APR(APR), .CNTW(CNTW), .LAT(LAT), .TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // NCO model: output valid from the LAT-th enabled cycle; pipeline empties while disabled
  always @(posedge clk or negedge reset_n)
    if (!reset_n)                fill <= 0;
    else if (!bus.nco_clken)     fill <= 0;
    else if (fill < LAT - 1)     fill <= fill + 1;
  assign bus.nco_valid = nco_en && bus.nco_clken && (fill >= LAT - 1);

  typedef struct {
    bit              is_done;
    logic [CNTW-1:0] idx;
    logic [APR-1:0]  phi;
    bit              err;
    int              at;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_smp(input int at, input int idx, input logic [APR-1:0] phi);
    exp_t e;
    e.is_done = 1'b0; e.idx = CNTW'(idx); e.phi = phi; e.err = 1'b0; e.at = at;
    q.push_back(e);
  endtask

  task automatic push_done(input int at, input bit err);
    exp_t e;
    e.is_done = 1'b1; e.idx = '0; e.phi = '0; e.err = err; e.at = at;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (bus.nco_clken) hi_cnt <= hi_cnt + 1;
      if (bus.smp_valid) sv_cnt <= sv_cnt + 1;
      if (bus.smp_valid) begin
        if (q.size() == 0) chk("unexpected_sample", 64'(bus.smp_idx), 64'hFFFF);
        else begin
          e = q.pop_front();
          chk("sample_kind", 64'(e.is_done), 64'd0);
          chk("smp_idx", 64'(bus.smp_idx), 64'(e.idx));
          chk("nco_phi_inc", 64'(bus.nco_phi_inc), 64'(e.phi));
          chk("sample_cycle", 64'(cyc), 64'(e.at));
        end
      end
      if (bus.done) begin
        if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("done_kind", 64'(e.is_done), 64'd1);
          chk("done_err", 64'(bus.err), 64'(e.err));
          chk("done_cycle", 64'(cyc), 64'(e.at));
          chk("done_busy", 64'(bus.busy), 64'd0);
        end
      end
    end
  end

  task automatic start_burst(input logic [APR-1:0] inc, input logic [APR-1:0] step,
                             input logic [CNTW-1:0] len, output int t0);
    @(negedge clk);
    bus.cfg_inc = inc; bus.cfg_step = step; bus.cfg_len = len;
    bus.start = 1'b1; t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (30) @(negedge clk);
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin : stim
    int t0, h0, s0;
    logic [APR-1:0] t2_phi [4];
    logic [APR-1:0] t3_phi [3];
    t2_phi = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200, 32'h1000_0300};
    t3_phi = '{32'hFFFF_FF00, 32'h0000_0100, 32'h0000_0300};
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.cfg_inc = '0; bus.cfg_step = '0; bus.cfg_len = '0;

    repeat (3) @(negedge clk);
    chk("rst_clken", 64'(bus.nco_clken), 64'd0);
    chk("rst_phi", 64'(bus.nco_phi_inc), 64'd0);
    chk("rst_smp_valid", 64'(bus.smp_valid), 64'd0);
    chk("rst_idx", 64'(bus.smp_idx), 64'd0);
    chk("rst_busy_done_err", {61'd0, bus.busy, bus.done, bus.err}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: constant increment, 16 samples
    h0 = hi_cnt; s0 = sv_cnt;
    start_burst(32'h0333_3333, 32'h0, 16'd16, t0);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    for (int k = 0; k < 16; k++) push_smp(t0 + 9 + k, k, 32'h0333_3333);
    push_done(t0 + 25, 1'b0);
    drain("t1_drain");
    chk("t1_clken_cycles", 64'(hi_cnt - h0), 64'd24);
    chk("t1_smp_count", 64'(sv_cnt - s0), 64'd16);
    chk("t1_idx_idle", 64'(bus.smp_idx), 64'd0);

    // T2: chirp; a start in the DONE cycle is dropped
    start_burst(32'h1000_0000, 32'h0000_0100, 16'd4, t0);
    for (int k = 0; k < 4; k++) push_smp(t0 + 9 + k, k, t2_phi[k]);
    push_done(t0 + 13, 1'b0);
    wait_cyc(t0 + 13);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t2_done_cycle_start_ignored", 64'(bus.busy), 64'd0);
    drain("t2_drain");
    chk("t2_phi_hold", 64'(bus.nco_phi_inc), 64'h1000_0400);

    // T3: increment wraps mod 2^32
    start_burst(32'hFFFF_FF00, 32'h0000_0200, 16'd3, t0);
    for (int k = 0; k < 3; k++) push_smp(t0 + 9 + k, k, t3_phi[k]);
    push_done(t0 + 12, 1'b0);
    drain("t3_drain");

    // T4: empty burst
    h0 = hi_cnt; s0 = sv_cnt;
    start_burst(32'h1234_5678, 32'h1, 16'd0, t0);
    push_done(t0 + 1, 1'b0);
    drain("t4_drain");
    chk("t4_clken_cycles", 64'(hi_cnt - h0), 64'd0);
    chk("t4_smp_count", 64'(sv_cnt - s0), 64'd0);

    // T5: fill timeout, then next start clears err
    nco_en = 1'b0;
    start_burst(32'h0000_1000, 32'h0, 16'd4, t0);
    push_done(t0 + 13, 1'b1);
    drain("t5_drain");
    chk("t5_err_sticky", 64'(bus.err), 64'd1);
    nco_en = 1'b1;
    start_burst(32'h0000_0040, 32'h0000_0001, 16'd2, t0);
    chk("t5_err_cleared", 64'(bus.err), 64'd0);
    push_smp(t0 + 9, 0, 32'h0000_0040);
    push_smp(t0 + 10, 1, 32'h0000_0041);
    push_done(t0 + 11, 1'b0);
    drain("t5b_drain");

    // T6: abort at smp_idx 5
    start_burst(32'h0000_0800, 32'h0000_0010, 16'd16, t0);
    for (int k = 0; k < 6; k++) push_smp(t0 + 9 + k, k, 32'h0000_0800 + 32'(k) * 32'h10);
    wait_cyc(t0 + 14);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t6_abort_clken", 64'(bus.nco_clken), 64'd0);
    chk("t6_abort_busy", 64'(bus.busy), 64'd0);
    chk("t6_abort_smp_valid", 64'(bus.smp_valid), 64'd0);
    drain("t6_drain");

    // start and abort together: abort wins
    @(negedge clk);
    bus.cfg_len = 16'd4; bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("t6_start_abort_busy", 64'(bus.busy), 64'd0);
    chk("t6_start_abort_clken", 64'(bus.nco_clken), 64'd0);

    // start while busy is ignored, config held
    start_burst(32'h0000_0100, 32'h0000_0010, 16'd2, t0);
    wait_cyc(t0 + 3);
    bus.cfg_inc = 32'h0000_0999; bus.cfg_len = 16'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    push_smp(t0 + 9, 0, 32'h0000_0100);
    push_smp(t0 + 10, 1, 32'h0000_0110);
    push_done(t0 + 11, 1'b0);
    drain("t6c_drain");

    // T7: nco_valid gap in RUN holds index and increment
    start_burst(32'h0000_2000, 32'h0000_0004, 16'd3, t0);
    push_smp(t0 + 9, 0, 32'h0000_2000);
    push_smp(t0 + 12, 1, 32'h0000_2004);
    push_smp(t0 + 13, 2, 32'h0000_2008);
    push_done(t0 + 14, 1'b0);
    wait_cyc(t0 + 10);
    nco_en = 1'b0;
    wait_cyc(t0 + 12);
    nco_en = 1'b1;
    drain("t7_drain");

    // async reset mid-burst
    start_burst(32'h0000_0077, 32'h0000_0001, 16'd16, t0);
    for (int k = 0; k < 16; k++) push_smp(t0 + 9 + k, k, 32'h0000_0077 + 32'(k));
    push_done(t0 + 25, 1'b0);
    wait_cyc(t0 + 12);
    reset_n = 1'b0;
    #1;
    chk("arst_clken", 64'(bus.nco_clken), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_smp_valid", 64'(bus.smp_valid), 64'd0);
    chk("arst_idx_phi", {16'd0, bus.smp_idx, bus.nco_phi_inc}, 64'd0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    drain("arst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
